uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//   UART receiver (8N1, LSB first) that consumes the serial line driven by the
//   uart_tx string sender and returns whole bytes with a one-cycle valid strobe.
//   Downstream stage of the TX path; used for loopback checking of transmitted
//   strings on hardware and in simulation. Single clock domain; rx is asynchronous.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency in Hz
//   BAUD       9600        line rate in bit/s
//   BIT_CNT    CLK_FREQ/BAUD (localparam, 5208 at defaults): clocks per bit
//   HALF_CNT   BIT_CNT/2 (localparam, 2604): clocks to mid-bit
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  serial line, idle high, asynchronous
//   rx_data    out  8  last correctly received byte
//   rx_valid   out  1  one-cycle strobe: rx_data updated this cycle
//   frame_err  out  1  one-cycle strobe: stop bit sampled low
//   rx_busy    out  1  high from start-bit detection to return to IDLE
// BEHAVIOUR
//   - Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE,
//     counters=0, synchronizer flops=1 (line idle). Reset wins over any other event.
//   - rx passes a 2-flop synchronizer; a third flop gives the falling-edge detect.
//   - FSM: IDLE -> START -> DATA -> STOP -> IDLE; STOP -> WAIT_HI on framing error.
//   - IDLE: falling edge on synchronized rx -> START, baud counter cleared.
//   - START: at HALF_CNT, sample rx: 1 -> glitch, back to IDLE, no strobe;
//     0 -> DATA, bit index=0, counter cleared.
//   - DATA: sample every BIT_CNT clocks (mid-bit); shift into bit[index]
//     LSB first; after index 7 -> STOP.
//   - STOP: sample at mid-bit. 1 -> rx_data<=shift reg, rx_valid=1 for exactly one
//     cycle, -> IDLE. 0 -> frame_err=1 for one cycle, rx_data unchanged -> WAIT_HI.
//   - WAIT_HI: stay until synchronized rx==1, then -> IDLE (no false restart on
//     a break/low line).
//   - Returning to IDLE at mid-stop lets a back-to-back start bit (zero idle gap)
//     be caught; no byte is dropped at full line rate.
//   - Latency: rx_valid asserts 1 clk after the mid-stop sample, which is
//     ~9.5 bit times + 3 clk after the start-bit falling edge on rx.
//   - Baud counter width = $clog2(BIT_CNT); wraps to 0 on every sample point.
//   - rx_valid and frame_err never assert in the same cycle.
//   - rst asserted mid-frame: partial byte discarded, no strobe, IDLE next cycle.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: an even-parity bit is expected between D7 and stop;
//     FSM adds state PARITY after DATA; extra output parity_err (1 bit, reset 0)
//     strobes one cycle at the stop sample when parity mismatches; rx_valid is
//     suppressed and rx_data kept for that byte. Frame = 11 bits.
//   Not defined: 8N1, no PARITY state, no parity_err port.
// TESTING (CLK_FREQ=50 MHz, BAUD=9600, 20 ns clk)
//   1. Reset 5 clk, send 0x55 -> one rx_valid pulse, rx_data=8'h55, frame_err=0.
//   2. Send "Hi\n" (0x48,0x69,0x0A) back-to-back, no idle gap -> three rx_valid
//      pulses, rx_data 0x48,0x69,0x0A in order, spacing 52080 clk.
//   3. Drive rx low for 1000 clk then high -> no rx_valid, no frame_err,
//      rx_busy drops after HALF_CNT sample.
//   4. Send 0xA3 with stop bit 0, hold rx low 3 bit times, then 0x3C -> one
//      frame_err pulse, rx_data stays previous value, then rx_valid with 0x3C.
//   5. Assert rst at bit 4 of 0xF0, release, send 0x0F -> no strobe for 0xF0,
//      single rx_valid with rx_data=8'h0F.
//   6. UART_RX_PARITY_EN: send 0x07 with parity 1 -> rx_valid, 0x07; with
//      parity 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, mid-bit sampling.
// Returns each byte with a one-cycle rx_valid strobe and flags a low stop bit
// with a one-cycle frame_err strobe.
// Optional build macro UART_RX_PARITY_EN: expects an even-parity bit between
// D7 and the stop bit and adds the parity_err strobe output.
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HI
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            par_reg, par_next;
    logic            perr_reg, perr_next;
`endif

    // sync_reg[1] is the synchronized line; sync_reg[2] is its previous value
    logic [2:0] sync_reg;
    logic       rx_sync;
    logic       rx_fall;

    assign rx_sync = sync_reg[1];
    assign rx_fall = sync_reg[2] & ~sync_reg[1];

    // Two-flop synchronizer plus edge-detect flop; resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], rx};
        end
    end

    // FSM state, baud counter, shift register and output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state logic: sample at mid-start, then every full bit period
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (rx_fall) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        // line back high at mid-start: treat as a glitch
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                        idx_next   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = rx_sync;
                    idx_next            = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_sync;
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (!rx_sync) begin
                        // low stop bit: wait for the line to go high before rearming
                        ferr_next  = 1'b1;
                        state_next = ST_WAIT_HI;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shift_reg) != par_reg) begin
                        perr_next  = 1'b1;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        // back to IDLE at mid-stop so a zero-gap start bit is caught
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HI: begin
                cnt_next = '0;
                if (rx_sync) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign rx_busy   = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and randomized frames against a queue-based
// expectation model of the UART receiver (scaled baud for short runs).
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN   = 1;
`else
    localparam int PAR_EN   = 0;
`endif
    localparam int FRAME    = 10 + PAR_EN;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    always #10 clk = ~clk;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy   (rx_busy)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // kind: 0 = good byte, 1 = framing error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_valid_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and compare any strobe against the expectation queue
    task automatic step();
        exp_t e;
        int   kind_got;
        @(negedge clk);
        cyc++;
        if (rx_valid || frame_err || parity_err) begin
            $display("[cyc %0d] strobe valid=%0b ferr=%0b perr=%0b data=%02h",
                     cyc, rx_valid, frame_err, parity_err, rx_data);
            check("single_strobe", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 1);
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                kind_got = rx_valid ? 0 : (frame_err ? 1 : 2);
                check("strobe_kind", kind_got, e.kind);
                check(e.kind == 0 ? "rx_data" : "rx_data_kept", rx_data, e.data);
                if (rx_valid) begin
                    if (e.gap != 0) check("spacing", cyc - last_valid_cyc, e.gap);
                    last_valid_cyc = cyc;
                end
            end
        end
    endtask

    // Drive one frame; rx is left at the stop-bit level for the caller
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input int gap_chk);
        exp_t e;
        e.gap = 0;
        if (!stop_ok) begin
            e.kind = 1;
            e.data = model_data;
        end else if (PAR_EN != 0 && !par_ok) begin
            e.kind = 2;
            e.data = model_data;
        end else begin
            e.kind = 0;
            e.data = d;
            e.gap  = gap_chk;
            model_data = d;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) step();
        end
        if (PAR_EN != 0) begin
            rx = par_ok ? (^d) : ~(^d);
            repeat (BIT) step();
        end
        rx = stop_ok;
        repeat (BIT) step();
    endtask

    // Start a frame, then reset the receiver at the start of data bit k
    task automatic send_abort(input logic [7:0] d, input int k);
        rx = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < k; i++) begin
            rx = d[i];
            repeat (BIT) step();
        end
        check("busy_mid_frame", rx_busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        model_data = 8'h00;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", rx_busy, 0);
        repeat ((9 - k + PAR_EN) * BIT) step();
    endtask

    // Short low pulse on the line: must be rejected at mid-start
    task automatic glitch(input int len);
        for (int s = 0; s < 3 * BIT; s++) begin
            rx = (s < len) ? 1'b0 : 1'b1;
            step();
            if (s == 5) check("glitch_busy", rx_busy, 1);
        end
        check("glitch_idle", rx_busy, 0);
    endtask

    initial begin
        logic [7:0] d;
        bit         stop_ok;
        bit         par_ok;
        bit         ok;
        bit         prev_b2b;
        int         r;
        int         gap;

        model_data = 8'h00;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) step();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", rx_busy, 0);
        rst = 1'b0;
        repeat (BIT) step();

        // single byte
        send_frame(8'h55, 1'b1, 1'b1, 0);
        rx = 1'b1;
        repeat (BIT) step();
        check("idle_after_55", rx_busy, 0);

        // "Hi\n" back to back with no idle gap
        send_frame(8'h48, 1'b1, 1'b1, 0);
        send_frame(8'h69, 1'b1, 1'b1, FRAME * BIT);
        send_frame(8'h0A, 1'b1, 1'b1, FRAME * BIT);
        rx = 1'b1;
        repeat (BIT) step();

        // glitch shorter than half a bit
        glitch(HALF - 3);

        // framing error followed by a 3-bit break, then a good byte
        send_frame(8'hA3, 1'b0, 1'b1, 0);
        rx = 1'b0;
        repeat (3 * BIT) step();
        check("break_busy", rx_busy, 1);
        rx = 1'b1;
        repeat (BIT) step();
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        rx = 1'b1;
        repeat (BIT) step();

        // reset in the middle of 0xF0, then a clean 0x0F
        send_abort(8'hF0, 4);
        send_frame(8'h0F, 1'b1, 1'b1, 0);
        rx = 1'b1;
        repeat (BIT) step();

        if (PAR_EN != 0) begin
            send_frame(8'h07, 1'b1, 1'b1, 0);
            rx = 1'b1;
            repeat (BIT) step();
            send_frame(8'h07, 1'b1, 1'b0, 0);
            rx = 1'b1;
            repeat (BIT) step();
        end

        // randomized traffic: bursts, gaps, glitches, bad stop/parity bits
        prev_b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                glitch($urandom_range(1, HALF - 3));
                prev_b2b = 1'b0;
                continue;
            end
            d       = 8'($urandom);
            r       = $urandom_range(0, 9);
            stop_ok = (r != 0);
            par_ok  = (r != 1);
            ok      = stop_ok && (PAR_EN == 0 || par_ok);
            send_frame(d, stop_ok, par_ok, (prev_b2b && ok) ? FRAME * BIT : 0);
            if (!stop_ok) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 3) * BIT) step();
                gap = BIT + $urandom_range(0, BIT);
            end else begin
                gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * BIT) : 0;
            end
            rx = 1'b1;
            repeat (gap) step();
            prev_b2b = ok && (gap == 0);
        end

        rx = 1'b1;
        repeat (2 * BIT) step();
        check("pending_events", exp_q.size(), 0);
        check("final_idle", rx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
